// File: rtl/ram_pkg.sv
// ram_pkg: shared state type and default geometry for the clearable dual-port RAM
package ram_pkg;
    typedef enum logic {CLEAR, IDLE} state_t;
    localparam int DEF_WIDTH    = 32;
    localparam int DEF_DEPTH    = 16;
    localparam int DEF_ADDRESS  = 4;
    localparam int DEF_READ_LAT = 1;
endpackage

// File: rtl/ram_dp_clr_if.sv
// ram_dp_clr_if: user write/read/clear port bundle of the clearable dual-port RAM
interface ram_dp_clr_if import ram_pkg::*; #(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int ADDRESS = DEF_ADDRESS
);
    logic               wr_enb;
    logic [ADDRESS-1:0] wr_addr;
    logic [WIDTH-1:0]   data_in;
    logic [WIDTH/8-1:0] byte_en;
    logic               rd_enb;
    logic [ADDRESS-1:0] rd_addr;
    logic               clr_req;
    logic [WIDTH-1:0]   data_out;
    logic               rd_valid;
    logic               init_busy;
    modport master (output wr_enb, wr_addr, data_in, byte_en, rd_enb, rd_addr, clr_req,
                    input data_out, rd_valid, init_busy);
    modport slave (input wr_enb, wr_addr, data_in, byte_en, rd_enb, rd_addr, clr_req,
                   output data_out, rd_valid, init_busy);
endinterface

// File: rtl/ram_clr_ctrl.sv
// ram_clr_ctrl: init FSM sweeping a zero write over every word after reset or a clear request
module ram_clr_ctrl import ram_pkg::*; #(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int ADDRESS = DEF_ADDRESS
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clr_req_i,
    output logic               init_busy_o,
    output logic               clr_we_o,
    output logic [ADDRESS-1:0] clr_addr_o
);
    localparam logic [ADDRESS-1:0] LAST = ADDRESS'(DEPTH - 1);
    state_t             state_q, state_d;
    logic [ADDRESS-1:0] cnt_q, cnt_d;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == CLEAR) begin
            state_d = cnt_q == LAST ? IDLE : CLEAR;
            cnt_d   = cnt_q == LAST ? '0 : cnt_q + 1'b1;
        end else if (clr_req_i) begin
            state_d = CLEAR;
            cnt_d   = '0;
        end
    end
    assign init_busy_o = state_q == CLEAR;
    assign clr_we_o    = state_q == CLEAR;
    assign clr_addr_o  = cnt_q;
endmodule

// File: rtl/ram_dp_clr.sv
// ram_dp_clr: byte-maskable dual-port RAM with self-clearing init and 1/2-cycle read pipeline
module ram_dp_clr import ram_pkg::*; #(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ADDRESS  = DEF_ADDRESS,
    parameter int READ_LAT = DEF_READ_LAT,
    parameter int RDW_MODE = 0
) (
    input logic         clock,
    input logic         reset,
    ram_dp_clr_if.slave bus
);
    localparam int NB = WIDTH / 8;
    localparam logic [ADDRESS:0] DEPTH_W = (ADDRESS + 1)'(DEPTH);
    logic [WIDTH-1:0]   mem [DEPTH];
    logic               busy, clr_we;
    logic [ADDRESS-1:0] clr_addr;
    logic               user_ok, wr_in, rd_in, wr_go, rd_go, rdw_hit;
    logic [WIDTH-1:0]   wr_old, wr_new, rd_data_d, dout1_q;
    logic               vld1_q;
    ram_clr_ctrl #(.DEPTH(DEPTH), .ADDRESS(ADDRESS)) u_ctrl (
        .clock(clock), .reset(reset), .clr_req_i(bus.clr_req),
        .init_busy_o(busy), .clr_we_o(clr_we), .clr_addr_o(clr_addr)
    );
    // a clear request blocks user traffic on the very edge it is sampled
    assign user_ok = !busy && !bus.clr_req;
    assign wr_in   = {1'b0, bus.wr_addr} < DEPTH_W;
    assign rd_in   = {1'b0, bus.rd_addr} < DEPTH_W;
    assign wr_go   = user_ok && bus.wr_enb && wr_in;
    assign rd_go   = user_ok && bus.rd_enb;
    always_comb begin
        wr_old = wr_in ? mem[bus.wr_addr] : '0;
        wr_new = wr_old;
        for (int b = 0; b < NB; b++)
            wr_new[8*b +: 8] = bus.byte_en[b] ? bus.data_in[8*b +: 8] : wr_old[8*b +: 8];
    end
    assign rdw_hit   = RDW_MODE == 1 && wr_go && bus.wr_addr == bus.rd_addr;
    assign rd_data_d = !rd_in ? '0 : rdw_hit ? wr_new : mem[bus.rd_addr];
    always_ff @(posedge clock) begin
        if (clr_we)
            mem[clr_addr] <= '0;
        else if (wr_go)
            mem[bus.wr_addr] <= wr_new;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dout1_q <= '0;
            vld1_q  <= 1'b0;
        end else begin
            vld1_q  <= rd_go;
            dout1_q <= rd_go ? rd_data_d : dout1_q;
        end
    end
    generate
        if (READ_LAT == 2) begin : g_lat2
            logic [WIDTH-1:0] dout2_q;
            logic             vld2_q;
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    dout2_q <= '0;
                    vld2_q  <= 1'b0;
                end else begin
                    vld2_q  <= vld1_q;
                    dout2_q <= vld1_q ? dout1_q : dout2_q;
                end
            end
            assign bus.data_out = dout2_q;
            assign bus.rd_valid = vld2_q;
        end else begin : g_lat1
            assign bus.data_out = dout1_q;
            assign bus.rd_valid = vld1_q;
        end
    endgenerate
    assign bus.init_busy = busy;
endmodule

// File: tb/tb_ram_dp_clr.sv
// tb_ram_dp_clr: directed plus random checks of two RAM configurations against a word-array model
module tb_ram_dp_clr;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic        we, re, cr;
    logic [4:0]  wa, ra;
    logic [31:0] din;
    logic [3:0]  be;
    int checks = 0;
    int errors = 0;

    // A: default geometry, latency 1, old-data RDW; B: 5-bit address (16..31 out of range), latency 2, new-data RDW
    ram_dp_clr_if #(.WIDTH(32), .ADDRESS(4)) ia ();
    ram_dp_clr_if #(.WIDTH(32), .ADDRESS(5)) ib ();
    assign ia.wr_enb = we;  assign ib.wr_enb = we;
    assign ia.wr_addr = wa[3:0]; assign ib.wr_addr = wa;
    assign ia.data_in = din; assign ib.data_in = din;
    assign ia.byte_en = be; assign ib.byte_en = be;
    assign ia.rd_enb = re;  assign ib.rd_enb = re;
    assign ia.rd_addr = ra[3:0]; assign ib.rd_addr = ra;
    assign ia.clr_req = cr; assign ib.clr_req = cr;

    ram_dp_clr #(.WIDTH(32), .DEPTH(16), .ADDRESS(4), .READ_LAT(1), .RDW_MODE(0)) dut_a (
        .clock(clock), .reset(reset), .bus(ia.slave));
    ram_dp_clr #(.WIDTH(32), .DEPTH(16), .ADDRESS(5), .READ_LAT(2), .RDW_MODE(1)) dut_b (
        .clock(clock), .reset(reset), .bus(ib.slave));

    logic [31:0] mm [2][16];
    int          clr_left, clr_idx;
    logic [31:0] ea_d, s1_d, eb_d;
    logic        ea_v, s1_v, eb_v;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) if (m[k]) r[8*k +: 8] = nw[8*k +: 8];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        clr_left = 16; clr_idx = 0;
        ea_d = 0; ea_v = 0; s1_d = 0; s1_v = 0; eb_d = 0; eb_v = 0;
    endtask

    task automatic model_edge();
        logic [31:0] rv [2];
        logic [31:0] old, mg;
        logic        acc;
        int          wi, ri;
        eb_v = s1_v;
        if (s1_v) eb_d = s1_d;
        acc = 1'b0;
        rv[0] = 0; rv[1] = 0;
        if (clr_left > 0) begin
            mm[0][clr_idx] = 0; mm[1][clr_idx] = 0;
            clr_idx++; clr_left--;
        end else if (cr) begin
            clr_left = 16; clr_idx = 0;
        end else begin
            acc = re;
            for (int i = 0; i < 2; i++) begin
                wi = (i == 0) ? int'(wa[3:0]) : int'(wa);
                ri = (i == 0) ? int'(ra[3:0]) : int'(ra);
                old = (ri < 16) ? mm[i][ri] : 32'h0;
                mg  = (wi < 16) ? merge(mm[i][wi], din, be) : 32'h0;
                rv[i] = (ri >= 16) ? 32'h0 : (i == 1 && we && wi == ri) ? mg : old;
                if (we && wi < 16) mm[i][wi] = mg;
            end
        end
        ea_v = acc; if (acc) ea_d = rv[0];
        s1_v = acc; if (acc) s1_d = rv[1];
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_a_dout"}, ia.data_out, ea_d);
        chk({tag, "_a_vld"}, 32'(ia.rd_valid), 32'(ea_v));
        chk({tag, "_a_busy"}, 32'(ia.init_busy), 32'(clr_left > 0));
        chk({tag, "_b_dout"}, ib.data_out, eb_d);
        chk({tag, "_b_vld"}, 32'(ib.rd_valid), 32'(eb_v));
        chk({tag, "_b_busy"}, 32'(ib.init_busy), 32'(clr_left > 0));
    endtask

    task automatic tick(input string tag);
        @(posedge clock);
        if (reset) model_reset(); else model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic w, input int wadr, input logic [31:0] d, input logic [3:0] m,
                         input logic r, input int radr, input logic c);
        we = w; wa = 5'(wadr); din = d; be = m; re = r; ra = 5'(radr); cr = c;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) for (int j = 0; j < 16; j++) mm[i][j] = 0;
        idle();
        #2 reset = 1'b1;
        model_reset();
        #1 check_all("rst_async");
        repeat (3) tick("rst_hold");
        reset = 1'b0;
        repeat (16) tick("init");
        drive(0, 0, 0, 0, 1, 10, 0); tick("rd10");
        chk("rd10_a", ia.data_out, 32'h0);
        idle(); tick("rd10_b");
        chk("rd10_b_lit", ib.data_out, 32'h0);

        drive(1, 10, 32'hC3C3C3C3, 4'hF, 0, 0, 0); tick("wr10");
        drive(0, 0, 0, 0, 1, 10, 0); tick("wr10_rd");
        chk("wr10_a_lit", ia.data_out, 32'hC3C3C3C3);
        chk("wr10_a_vld_lit", 32'(ia.rd_valid), 32'h1);
        idle(); tick("wr10_rd2");
        chk("wr10_b_lit", ib.data_out, 32'hC3C3C3C3);

        drive(1, 3, 32'h11223344, 4'hF, 0, 0, 0); tick("bm_init");
        drive(1, 3, 32'hAABBCCDD, 4'b0101, 0, 0, 0); tick("bm_wr");
        drive(0, 0, 0, 0, 1, 3, 0); tick("bm_rd");
        chk("bm_a_lit", ia.data_out, 32'h11BB33DD);
        idle(); tick("bm_rd2");
        chk("bm_b_lit", ib.data_out, 32'h11BB33DD);

        drive(1, 5, 32'h12345678, 4'hF, 1, 5, 0); tick("rdw");
        chk("rdw_a_old", ia.data_out, 32'h0);
        idle(); tick("rdw2");
        chk("rdw_b_new", ib.data_out, 32'h12345678);

        drive(0, 0, 0, 0, 1, 10, 0); tick("b2b0");
        drive(0, 0, 0, 0, 1, 3, 0);  tick("b2b1");
        drive(0, 0, 0, 0, 1, 5, 0);  tick("b2b2");
        idle(); repeat (2) tick("b2b_tail");

        drive(1, 20, 32'hDEADBEEF, 4'hF, 0, 0, 0); tick("oor_wr");
        drive(0, 0, 0, 0, 1, 20, 0); tick("oor_rd");
        chk("oor_a_alias", ia.data_out, 32'hDEADBEEF);
        idle(); tick("oor_rd2");
        chk("oor_b_zero", ib.data_out, 32'h0);
        chk("oor_b_vld", 32'(ib.rd_valid), 32'h1);

        for (int a = 0; a < 16; a++) begin
            drive(1, a, 32'h01010101 * (a + 1), 4'hF, 0, 0, 0); tick("fill");
        end
        drive(1, 2, 32'hFFFFFFFF, 4'hF, 1, 2, 1); tick("clr_req");
        for (int k = 0; k < 16; k++) begin
            drive(1, k, 32'hA5A5A5A5, 4'hF, 1, k, 0); tick("clr_busy");
        end
        chk("clr_done_busy", 32'(ia.init_busy), 32'h0);
        for (int a = 0; a < 16; a++) begin
            drive(0, 0, 0, 0, 1, a, 0); tick("clr_rd");
            chk("clr_rd_a_zero", ia.data_out, 32'h0);
        end
        idle(); repeat (2) tick("clr_tail");

        drive(0, 0, 0, 0, 0, 0, 1); tick("mid_req");
        drive(0, 0, 0, 0, 1, 4, 0);
        repeat (7) tick("mid_clr");
        reset = 1'b1;
        model_reset();
        #1 check_all("mid_rst_async");
        repeat (2) tick("mid_rst_hold");
        reset = 1'b0;
        for (int k = 0; k < 16; k++) begin
            drive(1, k, 32'h5A5A5A5A, 4'hF, 1, k, 0); tick("mid_restart");
            chk("mid_restart_vld", 32'(ia.rd_valid), 32'h0);
        end
        idle(); tick("mid_after");

        repeat (400) begin
            drive($urandom_range(0, 1) == 1, $urandom_range(0, 19), $urandom, 4'($urandom),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 19), $urandom_range(0, 63) == 0);
            tick("rand");
        end
        idle(); repeat (3) tick("rand_tail");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
